// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, default baud
// divider and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with registered occupancy count and full flag.
// Writes into a full FIFO are ignored even if a pop happens in the same cycle.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_EMPTY = {(PTR_W + 1){1'b0}};
    localparam logic [PTR_W:0] COUNT_FULL  = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             full_r;
    logic [PTR_W:0]   count_next_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s  = push && !full_r;
    assign do_pop_s   = pop && (count_r != COUNT_EMPTY);
    assign pop_data   = mem_r[rd_ptr_r];
    assign full       = full_r;
    assign count      = count_r;
    assign count_next = count_next_s;

    // Occupancy after this cycle's accepted push/pop
    always_comb begin
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + (PTR_W + 1)'(1);
            2'b01:   count_next_s = count_r - (PTR_W + 1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage array; no reset needed since reads are guarded by the count
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, count and full flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= COUNT_EMPTY;
            full_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == COUNT_FULL);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a byte FIFO. Frames are sent back to back
// while bytes are queued; tx_busy drops at the end of the last stop bit.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    write_data,
    input  logic                          write_en,
    output logic                          tx_busy,
    output logic                          uart_tx,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e      state_r;
    uart_state_e      next_state_s;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [CNT_W-1:0] next_baud_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       next_bit_idx_s;
    logic [7:0]       shift_r;
    logic [7:0]       next_shift_s;
    logic             tx_r;
    logic             next_tx_s;
    logic             busy_r;
    logic             overflow_r;
    logic             pop_s;
    logic             baud_done_s;
    logic [7:0]       fifo_data_s;
    logic             fifo_full_s;
    logic [LVL_W-1:0] fifo_level_s;
    logic [LVL_W-1:0] level_next_s;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (write_en),
        .push_data  (write_data),
        .pop        (pop_s),
        .pop_data   (fifo_data_s),
        .full       (fifo_full_s),
        .count      (fifo_level_s),
        .count_next (level_next_s)
    );

    assign baud_done_s = (baud_cnt_r == BAUD_LAST);
    assign uart_tx     = tx_r;
    assign tx_busy     = busy_r;
    assign fifo_full   = fifo_full_s;
    assign fifo_level  = fifo_level_s;
    assign overflow    = overflow_r;

    // Frame sequencing: the line value for the next bit is registered at each boundary
    always_comb begin
        next_state_s   = state_r;
        next_baud_s    = baud_cnt_r;
        next_bit_idx_s = bit_idx_r;
        next_shift_s   = shift_r;
        next_tx_s      = tx_r;
        pop_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                next_baud_s = BAUD_ZERO;
                if (fifo_level_s != LVL_ZERO) begin
                    pop_s        = 1'b1;
                    next_shift_s = fifo_data_s;
                    next_tx_s    = 1'b0;
                    next_state_s = ST_START;
                end else begin
                    next_tx_s = 1'b1;
                end
            end
            ST_START: begin
                if (baud_done_s) begin
                    next_baud_s    = BAUD_ZERO;
                    next_tx_s      = shift_r[0];
                    next_shift_s   = {1'b0, shift_r[7:1]};
                    next_bit_idx_s = 3'd0;
                    next_state_s   = ST_DATA;
                end else begin
                    next_baud_s = baud_cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    next_baud_s = BAUD_ZERO;
                    if (bit_idx_r == LAST_BIT) begin
                        next_tx_s    = 1'b1;
                        next_state_s = ST_STOP;
                    end else begin
                        next_tx_s      = shift_r[0];
                        next_shift_s   = {1'b0, shift_r[7:1]};
                        next_bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    next_baud_s = baud_cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    next_baud_s = BAUD_ZERO;
                    // Chain straight into the next start bit when more data is queued
                    if (fifo_level_s != LVL_ZERO) begin
                        pop_s        = 1'b1;
                        next_shift_s = fifo_data_s;
                        next_tx_s    = 1'b0;
                        next_state_s = ST_START;
                    end else begin
                        next_tx_s    = 1'b1;
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_baud_s = baud_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                next_baud_s  = BAUD_ZERO;
                next_tx_s    = 1'b1;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            baud_cnt_r <= next_baud_s;
            bit_idx_r  <= next_bit_idx_s;
            shift_r    <= next_shift_s;
            tx_r       <= next_tx_s;
            busy_r     <= (next_state_s != ST_IDLE) || (level_next_s != LVL_ZERO);
            overflow_r <= overflow_r | (write_en & fifo_full_s);
        end
    end

endmodule
